alu_share_arbiter: RTL

Shares one combinational ALU instance (5-bit op code, N-bit operands) between NREQ requesters, for example the core pipeline and a memory/branch helper unit. It picks a requester round-robin, registers its operation, and drives the ALU from those registers. It waits a per-op latency so MUL/DIV can settle on slow combinational paths, then returns the registered result through a valid/ready response channel tagged with the requester id.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_share_arbiter_rr_arbiter.sv | 28 ++
 rtl/alu_share_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, FSM states and op legality.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 5'd1;
  localparam logic [OP_W-1:0] ALU_SUB = 5'd2;
  localparam logic [OP_W-1:0] ALU_MUL = 5'd3;
  localparam logic [OP_W-1:0] ALU_MOV = 5'd4;
  localparam logic [OP_W-1:0] ALU_DIV = 5'd5;
  localparam logic [OP_W-1:0] ALU_AND = 5'd9;
  localparam logic [OP_W-1:0] ALU_OR  = 5'd10;
  localparam logic [OP_W-1:0] ALU_XOR = 5'd11;
  localparam logic [OP_W-1:0] ALU_NOT = 5'd12;
  localparam logic [OP_W-1:0] ALU_LDR = 5'd17;
  localparam logic [OP_W-1:0] ALU_STR = 5'd19;
  localparam logic [OP_W-1:0] ALU_JE  = 5'd25;
  localparam logic [OP_W-1:0] ALU_JNE = 5'd26;
  localparam logic [OP_W-1:0] ALU_JLT = 5'd27;
  localparam logic [OP_W-1:0] ALU_JGT = 5'd28;
  localparam logic [OP_W-1:0] ALU_JGE = 5'd29;
  localparam logic [OP_W-1:0] ALU_JLE = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_MUL, ALU_MOV, ALU_DIV,
      ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_LDR, ALU_STR,
      ALU_JE, ALU_JNE, ALU_JLT, ALU_JGT, ALU_JGE, ALU_JLE: op_is_legal = 1'b1;
      default:                                             op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt_c
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr) + i) % NREQ);
      if (en && !found && req[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between NREQ requesters with per-op settle latency
// and a valid/ready response channel tagged with the requester id.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8,
  localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_ctrl,
  input  logic [NREQ*N-1:0]    req_a,
  input  logic [NREQ*N-1:0]    req_b,
  output logic [OP_W-1:0]      alu_ctrl,
  output logic [N-1:0]         alu_src_a,
  output logic [N-1:0]         alu_src_b,
  input  logic [N-1:0]         alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [N-1:0]         rsp_result,
  output logic                 rsp_err
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [N-1:0]    rsp_result_q, rsp_result_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]  gnt;
  logic             hs;
  logic [OP_W-1:0]  sel_ctrl;
  logic [N-1:0]     sel_a, sel_b;
  logic [IDW-1:0]   sel_id;
  logic [CNT_W-1:0] sel_cnt;
  logic             exec_err;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (state_q == ST_IDLE),
    .gnt_c (gnt)
  );

  assign hs = |(gnt & req_valid);

  // Mux the granted requester's payload out of the flattened buses.
  always_comb begin
    sel_ctrl = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_id   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_ctrl = req_ctrl[OP_W*i +: OP_W];
        sel_a    = req_a[N*i +: N];
        sel_b    = req_b[N*i +: N];
        sel_id   = IDW'(i);
      end
    end
  end

  always_comb begin
    case (sel_ctrl)
      ALU_MUL: sel_cnt = CNT_W'(MUL_LAT - 1);
      ALU_DIV: sel_cnt = CNT_W'(DIV_LAT - 1);
      default: sel_cnt = '0;
    endcase
  end

  assign exec_err = !op_is_legal(alu_ctrl_q) || ((alu_ctrl_q == ALU_DIV) && (alu_b_q == '0));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          id_d       = sel_id;
          cnt_d      = sel_cnt;
          alu_ctrl_d = sel_ctrl;
          alu_a_d    = sel_a;
          alu_b_d    = sel_b;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          rsp_valid_d  = 1'b1;
          rsp_err_d    = exec_err;
          rsp_result_d = exec_err ? '0 : alu_result;
          alu_ctrl_d   = '0;
          alu_a_d      = '0;
          alu_b_d      = '0;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = IDW'((32'(id_q) + 32'd1) % NREQ);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      alu_ctrl_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = gnt;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_src_a  = alu_a_q;
  assign alu_src_b  = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule
